// File: rtl/writeback_sequencer_pkg.sv
// ============================================================================
// Module   : writeback_sequencer_pkg
// Purpose  : Y86 icode constants, register specifiers and sequencer FSM states.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package writeback_sequencer_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR1  = 3'd1,
        S_WR_E = 3'd2,
        S_WR_M = 3'd3,
        S_HALT = 3'd4
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/writeback_sequencer_if.sv
// ============================================================================
// Module   : writeback_sequencer_if
// Purpose  : Retired-beat input and register-file write port bundle.
//            Optional forwarding signals present when WB_FWD_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface writeback_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic              cnd;
    logic [REG_AW-1:0] rA;
    logic [REG_AW-1:0] rB;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              reg_error;
    logic              func_error;
    logic              halted;
`ifdef WB_FWD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
`endif

    modport slave (
        input  in_valid, icode, cnd, rA, rB, valE, valM,
        output in_ready, wr_en, wr_addr, wr_data, reg_error, func_error, halted
`ifdef WB_FWD_EN
        , output fwd_valid, fwd_addr, fwd_data
`endif
    );

    modport master (
        output in_valid, icode, cnd, rA, rB, valE, valM,
        input  in_ready, wr_en, wr_addr, wr_data, reg_error, func_error, halted
`ifdef WB_FWD_EN
        , input fwd_valid, fwd_addr, fwd_data
`endif
    );

endinterface

`default_nettype wire

// File: rtl/writeback_sequencer_wb_dest_decode.sv
// ============================================================================
// Module   : wb_dest_decode
// Purpose  : Combinational icode/cnd/rA/rB to write-back destination decode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_dest_decode
    import writeback_sequencer_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [3:0]        icode_i,
    input  logic              cnd_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic [REG_AW-1:0] dst_e_o,
    output logic [REG_AW-1:0] dst_m_o,
    output logic              need_e_o,
    output logic              need_m_o,
    output logic              bad_icode_o
);
    localparam logic [REG_AW-1:0] C_RSP  = REG_AW'(REG_RSP);
    localparam logic [REG_AW-1:0] C_NONE = '1;

    always_comb begin
        dst_e_o     = C_NONE;
        dst_m_o     = C_NONE;
        need_e_o    = 1'b0;
        need_m_o    = 1'b0;
        bad_icode_o = 1'b0;
        case (icode_i)
            // A failed cmov is simply a no-write instruction.
            I_RRMOVQ: begin
                need_e_o = cnd_i;
                dst_e_o  = rb_i;
            end
            I_IRMOVQ, I_OPQ: begin
                need_e_o = 1'b1;
                dst_e_o  = rb_i;
            end
            I_MRMOVQ: begin
                need_m_o = 1'b1;
                dst_m_o  = ra_i;
            end
            I_CALL, I_RET, I_PUSHQ: begin
                need_e_o = 1'b1;
                dst_e_o  = C_RSP;
            end
            I_POPQ: begin
                need_e_o = 1'b1;
                dst_e_o  = C_RSP;
                need_m_o = 1'b1;
                dst_m_o  = ra_i;
            end
            I_HALT, I_NOP, I_RMMOVQ, I_JXX: begin
            end
            default: bad_icode_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_sequencer.sv
// ============================================================================
// Module   : writeback_sequencer
// Purpose  : Write-back stage sequencer; serialises dual writes, flags errors,
//            latches halt. WB_FWD_EN adds valM forwarding outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    writeback_sequencer_if.slave  bus
);
    localparam logic [REG_AW-1:0] C_NONE = '1;

    wb_state_t         state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              reg_err_q, reg_err_d;
    logic              func_err_q, func_err_d;
    logic              halted_q, halted_d;
    logic [REG_AW-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    logic [REG_AW-1:0] w_dst_e, w_dst_m;
    logic              w_need_e, w_need_m, w_bad_icode;
    logic              w_ready, w_accept;

    wb_dest_decode #(.REG_AW(REG_AW)) u_dest_decode (
        .icode_i     (bus.icode),
        .cnd_i       (bus.cnd),
        .ra_i        (bus.rA),
        .rb_i        (bus.rB),
        .dst_e_o     (w_dst_e),
        .dst_m_o     (w_dst_m),
        .need_e_o    (w_need_e),
        .need_m_o    (w_need_m),
        .bad_icode_o (w_bad_icode)
    );

    assign w_ready  = !rst && (state_q == S_IDLE || state_q == S_WR1 || state_q == S_WR_M);
    assign w_accept = bus.in_valid && w_ready;

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        reg_err_d  = 1'b0;
        func_err_d = 1'b0;
        halted_d   = halted_q;
        m_addr_d   = m_addr_q;
        m_data_d   = m_data_q;
        case (state_q)
            S_WR_E: begin
                wr_en_d   = (m_addr_q != C_NONE);
                wr_addr_d = m_addr_q;
                wr_data_d = m_data_q;
                reg_err_d = (m_addr_q == C_NONE);
                state_d   = S_WR_M;
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    if (w_bad_icode) begin
                        func_err_d = 1'b1;
                    end else if (bus.icode == I_HALT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (w_need_e && w_need_m) begin
                        // valE goes first so a popq to %rsp leaves rsp = valM.
                        wr_en_d   = 1'b1;
                        wr_addr_d = w_dst_e;
                        wr_data_d = bus.valE;
                        m_addr_d  = w_dst_m;
                        m_data_d  = bus.valM;
                        state_d   = S_WR_E;
                    end else if (w_need_e || w_need_m) begin
                        wr_addr_d = w_need_e ? w_dst_e : w_dst_m;
                        wr_data_d = w_need_e ? bus.valE : bus.valM;
                        wr_en_d   = (wr_addr_d != C_NONE);
                        reg_err_d = (wr_addr_d == C_NONE);
                        state_d   = S_WR1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            reg_err_q  <= 1'b0;
            func_err_q <= 1'b0;
            halted_q   <= 1'b0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            reg_err_q  <= reg_err_d;
            func_err_q <= func_err_d;
            halted_q   <= halted_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.reg_error  = reg_err_q;
    assign bus.func_error = func_err_q;
    assign bus.halted     = halted_q;

`ifdef WB_FWD_EN
    // Lets decode bypass the valM write still waiting in S_WR_E.
    assign bus.fwd_valid = (state_q == S_WR_E) && (m_addr_q != C_NONE);
    assign bus.fwd_addr  = m_addr_q;
    assign bus.fwd_data  = m_data_q;
`endif

endmodule

`default_nettype wire
